// File: rtl/sara_pkg.sv
// Shared definitions for the SARA approximate-adder error monitor.
// Contents:
//   sara_mode_e   - adder mode FSM encoding (approximate / exact carry-out)
//   Sara*Def      - default widths, window size, threshold and hold length
//   cnt_width()   - bit width of a counter that must reach a given maximum
package sara_pkg;

  typedef enum logic {
    StApprox = 1'b0,
    StExact  = 1'b1
  } sara_mode_e;

  localparam int unsigned SaraSizeDef    = 16;
  localparam int unsigned SaraWinLog2Def = 4;
  localparam int unsigned SaraErrThDef   = 2;
  localparam int unsigned SaraHoldWinDef = 2;

  // Width of a counter that must hold every value in 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sara_err_monitor_if.sv
// Bus bundle between the monitored adder / downstream consumer and the monitor.
//   upstream   : in_valid, in_ready, A, B, CIN, SUM_APX, COUT_APX
//   downstream : out_valid, out_ready, SUM, COUT, ERR, ERR_DIST
//   control    : MODE_EXACT (adder carryoutselect), WIN_DONE, WIN_ERRS
// master = stimulus/consumer side, slave = the monitor.
interface sara_err_monitor_if #(
  parameter int unsigned SIZE     = 16,
  parameter int unsigned WIN_LOG2 = 4
);
  logic                in_valid;
  logic                in_ready;
  logic [SIZE-1:0]     A;
  logic [SIZE-1:0]     B;
  logic                CIN;
  logic [SIZE-1:0]     SUM_APX;
  logic                COUT_APX;
  logic                out_valid;
  logic                out_ready;
  logic [SIZE-1:0]     SUM;
  logic                COUT;
  logic                ERR;
  logic [SIZE:0]       ERR_DIST;
  logic                MODE_EXACT;
  logic                WIN_DONE;
  logic [WIN_LOG2:0]   WIN_ERRS;

  modport master (
    output in_valid, A, B, CIN, SUM_APX, COUT_APX, out_ready,
    input  in_ready, out_valid, SUM, COUT, ERR, ERR_DIST, MODE_EXACT, WIN_DONE, WIN_ERRS
  );

  modport slave (
    input  in_valid, A, B, CIN, SUM_APX, COUT_APX, out_ready,
    output in_ready, out_valid, SUM, COUT, ERR, ERR_DIST, MODE_EXACT, WIN_DONE, WIN_ERRS
  );
endinterface

// File: rtl/sara_err_dist.sv
// Combinational error-distance unit.
// Ports:
//   i_a, i_b, i_cin        - adder operands
//   i_sum_apx, i_cout_apx  - approximate adder result for those operands
//   o_exact                - exact (SIZE+1)-bit sum A+B+CIN
//   o_err                  - exact and approximate results differ
//   o_dist                 - |exact - approx| in SIZE+1 bits
module sara_err_dist
  import sara_pkg::*;
#(
  parameter int unsigned SIZE = SaraSizeDef
) (
  input  logic [SIZE-1:0] i_a,
  input  logic [SIZE-1:0] i_b,
  input  logic            i_cin,
  input  logic [SIZE-1:0] i_sum_apx,
  input  logic            i_cout_apx,
  output logic [SIZE:0]   o_exact,
  output logic            o_err,
  output logic [SIZE:0]   o_dist
);

  logic [SIZE:0] w_exact;
  logic [SIZE:0] w_approx;

  always_comb begin
    w_exact  = {1'b0, i_a} + {1'b0, i_b} + {{SIZE{1'b0}}, i_cin};
    w_approx = {i_cout_apx, i_sum_apx};
    o_err    = (w_exact != w_approx);
    if (w_exact >= w_approx) begin
      o_dist = w_exact - w_approx;
    end else begin
      o_dist = w_approx - w_exact;
    end
  end

  assign o_exact = w_exact;

endmodule

// File: rtl/sara_err_monitor.sv
// Error monitor for an approximate adder with a switchable exact carry-out.
// Each accepted sample is compared against the exact sum; the registered
// result, mismatch flag and error distance are presented downstream with a
// one-cycle latency. Mismatches are counted over windows of 2^WIN_LOG2
// accepted samples; a window with more than ERR_TH errors switches the adder
// into exact mode for HOLD_WIN further windows.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - sara_err_monitor_if slave modport (handshakes, operands, results,
//          MODE_EXACT, WIN_DONE, WIN_ERRS)
module sara_err_monitor
  import sara_pkg::*;
#(
  parameter int unsigned SIZE     = SaraSizeDef,
  parameter int unsigned WIN_LOG2 = SaraWinLog2Def,
  parameter int unsigned ERR_TH   = SaraErrThDef,
  parameter int unsigned HOLD_WIN = SaraHoldWinDef
) (
  input logic            clk,
  input logic            rst,
  sara_err_monitor_if.slave bus
);

  localparam int unsigned     HoldW  = cnt_width(HOLD_WIN);
  localparam logic [WIN_LOG2:0] WinLen = {1'b1, {WIN_LOG2{1'b0}}};

  logic                w_in_ready;
  logic                w_accept;
  logic                w_win_last;
  logic                w_close;
  logic [SIZE:0]       w_exact;
  logic                w_err;
  logic [SIZE:0]       w_dist;
  logic [WIN_LOG2:0]   w_err_total;

  logic                r_out_valid;
  logic [SIZE-1:0]     r_sum;
  logic                r_cout;
  logic                r_err;
  logic [SIZE:0]       r_dist;
  logic [WIN_LOG2-1:0] r_smp_cnt;
  logic [WIN_LOG2:0]   r_err_cnt;
  logic                r_win_done;
  logic [WIN_LOG2:0]   r_win_errs;
  sara_mode_e          r_state;
  logic [HoldW-1:0]    r_hold;
  logic                r_mode_exact;

  sara_err_dist #(
    .SIZE (SIZE)
  ) u_err_dist (
    .i_a        (bus.A),
    .i_b        (bus.B),
    .i_cin      (bus.CIN),
    .i_sum_apx  (bus.SUM_APX),
    .i_cout_apx (bus.COUT_APX),
    .o_exact    (w_exact),
    .o_err      (w_err),
    .o_dist     (w_dist)
  );

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_win_last = &r_smp_cnt;
  assign w_close    = w_accept && w_win_last;

  // Error count including the sample being accepted, saturating at a full window.
  always_comb begin
    if (r_err_cnt == WinLen) begin
      w_err_total = r_err_cnt;
    end else begin
      w_err_total = r_err_cnt + {{WIN_LOG2{1'b0}}, w_err};
    end
  end

  // Output register: loads on every acceptance (including drain+accept in the
  // same cycle), otherwise empties once the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_err       <= 1'b0;
      r_dist      <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_sum       <= w_exact[SIZE-1:0];
      r_cout      <= w_exact[SIZE];
      r_err       <= w_err;
      r_dist      <= w_dist;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Window bookkeeping advances only on acceptance, so stalls never alter it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_smp_cnt  <= '0;
      r_err_cnt  <= '0;
      r_win_done <= 1'b0;
      r_win_errs <= '0;
    end else begin
      r_win_done <= w_close;
      if (w_accept) begin
        r_smp_cnt <= r_smp_cnt + {{(WIN_LOG2-1){1'b0}}, 1'b1};
        if (w_win_last) begin
          r_err_cnt  <= '0;
          r_win_errs <= w_err_total;
        end else begin
          r_err_cnt  <= w_err_total;
        end
      end
    end
  end

  // Mode FSM: only evaluated at a window close, so MODE_EXACT can only change
  // in the cycle that WIN_DONE pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= StApprox;
      r_hold       <= '0;
      r_mode_exact <= 1'b0;
    end else if (w_close) begin
      unique case (r_state)
        StApprox: begin
          if (32'(w_err_total) > ERR_TH) begin
            r_state      <= StExact;
            r_hold       <= HoldW'(HOLD_WIN);
            r_mode_exact <= 1'b1;
          end
        end
        StExact: begin
          // Leaving on the close that brings the hold count to zero.
          if (r_hold <= HoldW'(1)) begin
            r_state      <= StApprox;
            r_hold       <= '0;
            r_mode_exact <= 1'b0;
          end else begin
            r_hold <= r_hold - HoldW'(1);
          end
        end
        default: begin
          r_state      <= StApprox;
          r_hold       <= '0;
          r_mode_exact <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.SUM        = r_sum;
  assign bus.COUT       = r_cout;
  assign bus.ERR        = r_err;
  assign bus.ERR_DIST   = r_dist;
  assign bus.MODE_EXACT = r_mode_exact;
  assign bus.WIN_DONE   = r_win_done;
  assign bus.WIN_ERRS   = r_win_errs;

endmodule

// File: tb/tb_sara_err_monitor.sv
// Self-checking bench for sara_err_monitor: directed stimulus, a behavioural
// reference model, a per-cycle compare process and literal spot checks.
module tb_sara_err_monitor;

  localparam int unsigned SIZE     = 16;
  localparam int unsigned WIN_LOG2 = 4;
  localparam int unsigned ERR_TH   = 2;
  localparam int unsigned HOLD_WIN = 2;
  localparam int          WIN      = 1 << WIN_LOG2;
  localparam int          MOD      = 1 << SIZE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   cmp_en = 1'b0;

  always #5 clk = ~clk;

  sara_err_monitor_if #(.SIZE(SIZE), .WIN_LOG2(WIN_LOG2)) bus ();

  sara_err_monitor #(
    .SIZE     (SIZE),
    .WIN_LOG2 (WIN_LOG2),
    .ERR_TH   (ERR_TH),
    .HOLD_WIN (HOLD_WIN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_valid, m_win_done, m_mode;
  int m_sum, m_cout, m_err, m_dist, m_win_errs;
  int m_n, m_errs, m_left;

  always @(posedge clk or posedge rst) begin
    int exact, approx;
    if (rst) begin
      m_valid = 0; m_win_done = 0; m_mode = 0;
      m_sum = 0; m_cout = 0; m_err = 0; m_dist = 0; m_win_errs = 0;
      m_n = 0; m_errs = 0; m_left = 0;
    end else begin
      m_win_done = 0;
      if (bus.in_valid && (!m_valid || bus.out_ready)) begin
        exact  = int'(bus.A) + int'(bus.B) + int'(bus.CIN);
        approx = int'(bus.COUT_APX) * MOD + int'(bus.SUM_APX);
        m_sum  = exact % MOD;
        m_cout = exact / MOD;
        m_err  = (exact != approx) ? 1 : 0;
        m_dist = (exact > approx) ? exact - approx : approx - exact;
        m_valid = 1;
        m_n++;
        m_errs += m_err;
        if (m_n == WIN) begin
          m_win_done = 1;
          m_win_errs = m_errs;
          m_n = 0;
          m_errs = 0;
          if (!m_mode) begin
            if (m_win_errs > int'(ERR_TH)) begin
              m_mode = 1;
              m_left = HOLD_WIN;
            end
          end else begin
            m_left--;
            if (m_left <= 0) m_mode = 0;
          end
        end
      end else if (bus.out_ready) begin
        m_valid = 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      check("cmp_in_ready", bus.in_ready, (!m_valid || bus.out_ready));
      check("cmp_out_valid", bus.out_valid, m_valid);
      check("cmp_mode", bus.MODE_EXACT, m_mode);
      check("cmp_win_done", bus.WIN_DONE, m_win_done);
      check("cmp_win_errs", bus.WIN_ERRS, m_win_errs);
      if (m_valid) begin
        check("cmp_sum", bus.SUM, m_sum);
        check("cmp_cout", bus.COUT, m_cout);
        check("cmp_err", bus.ERR, m_err);
        check("cmp_dist", bus.ERR_DIST, m_dist);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_raw(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic [15:0] sapx, input logic capx);
    bus.A = a; bus.B = b; bus.CIN = cin; bus.SUM_APX = sapx; bus.COUT_APX = capx;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_gen(input bit bad);
    logic [15:0] a, b;
    logic        cin;
    logic [16:0] ex, ap;
    a   = 16'($urandom);
    b   = 16'($urandom);
    cin = 1'($urandom);
    ex  = {1'b0, a} + {1'b0, b} + {16'h0, cin};
    ap  = bad ? (ex ^ 17'h00011) : ex;
    send_raw(a, b, cin, ap[15:0], ap[16]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 0; bus.out_ready = 1; bus.A = 0; bus.B = 0; bus.CIN = 0;
    bus.SUM_APX = 0; bus.COUT_APX = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    cmp_en = 1;

    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_win_errs", bus.WIN_ERRS, 0);
    check("rst_mode", bus.MODE_EXACT, 0);

    // Matching result.
    send_raw(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
    check("m_valid", bus.out_valid, 1);
    check("m_sum", bus.SUM, 16'h0100);
    check("m_err", bus.ERR, 0);
    check("m_dist", bus.ERR_DIST, 0);

    // Mismatching result.
    send_raw(16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b0);
    check("x_err", bus.ERR, 1);
    check("x_dist", bus.ERR_DIST, 17'h00100);

    // Rest of window with 2 more mismatches: 3 > ERR_TH.
    for (int i = 0; i < 14; i++) send_gen(i == 4 || i == 9);
    check("w1_done", bus.WIN_DONE, 1);
    check("w1_errs", bus.WIN_ERRS, 3);
    check("w1_mode", bus.MODE_EXACT, 1);
    @(posedge clk);
    #1;
    check("w1_done_pulse", bus.WIN_DONE, 0);
    check("w1_mode_hold", bus.MODE_EXACT, 1);

    // Two windows in exact mode; errors in the first must not extend the hold.
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < WIN; i++) send_gen(w == 0 && i < 5);
      if (w == 0) begin
        check("e1_errs", bus.WIN_ERRS, 5);
        check("e1_mode", bus.MODE_EXACT, 1);
      end else begin
        check("e2_errs", bus.WIN_ERRS, 0);
        check("e2_mode", bus.MODE_EXACT, 0);
      end
    end

    // Stall with a pending sample, then back-to-back transfers.
    send_raw(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);
    bus.out_ready = 0;
    bus.A = 16'h1000; bus.B = 16'h0010; bus.CIN = 0; bus.SUM_APX = 16'h1010; bus.COUT_APX = 0;
    bus.in_valid = 1;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_sum", bus.SUM, 16'h2345);
      check("stall_valid", bus.out_valid, 1);
    end
    bus.out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("b2b_sum", bus.SUM, 16'h1010 + i);
      bus.A = 16'(16'h1001 + i);
      bus.SUM_APX = 16'(16'h1011 + i);
    end
    bus.in_valid = 0;

    // 5 samples in this window; close it with 3 errors to re-enter exact mode.
    for (int i = 0; i < 11; i++) send_gen(i < 3);
    check("w5_errs", bus.WIN_ERRS, 3);
    check("w5_mode", bus.MODE_EXACT, 1);

    // 9 samples into the next window, stall, then reset asynchronously.
    for (int i = 0; i < 9; i++) send_gen(i == 2);
    bus.out_ready = 0;
    bus.in_valid = 1;
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    check("ar_out_valid", bus.out_valid, 0);
    check("ar_sum", bus.SUM, 0);
    check("ar_err", bus.ERR, 0);
    check("ar_dist", bus.ERR_DIST, 0);
    check("ar_win_errs", bus.WIN_ERRS, 0);
    check("ar_mode", bus.MODE_EXACT, 0);
    bus.in_valid = 0;
    bus.out_ready = 1;
    @(negedge clk);
    rst = 0;
    #1;
    check("rel_in_ready", bus.in_ready, 1);
    check("rel_out_valid", bus.out_valid, 0);
    check("rel_win_errs", bus.WIN_ERRS, 0);

    // A fresh window needs exactly 16 accepted samples to close.
    for (int i = 0; i < WIN - 1; i++) begin
      send_gen(i == 1);
      check("fresh_no_done", bus.WIN_DONE, 0);
    end
    send_gen(1'b1);
    check("fresh_done", bus.WIN_DONE, 1);
    check("fresh_errs", bus.WIN_ERRS, 2);
    check("fresh_mode", bus.MODE_EXACT, 0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sara_err_monitor.md
SARA_ERR_MONITOR -- requirements
Module: sara_err_monitor

Interface
REQ-001 The block SHALL have parameter SIZE, default 16, giving the operand width of the monitored adder.
REQ-002 The block SHALL have parameter WIN_LOG2, default 4, where one window is 2^WIN_LOG2 accepted samples.
REQ-003 The block SHALL have parameter ERR_TH, default 2, the per-window error count above which exact mode is entered.
REQ-004 The block SHALL have parameter HOLD_WIN, default 2, the number of full windows spent in exact mode before returning to approximate mode.
REQ-005 The block SHALL have port clk, input, width 1, the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, width 1, asynchronous active-high reset.
REQ-007 The block SHALL have port in_valid (input, 1) and port in_ready (output, 1), the upstream handshake.
REQ-008 The block SHALL have ports A and B (input, SIZE each) and CIN (input, 1): the adder operands.
REQ-009 The block SHALL have ports SUM_APX (input, SIZE) and COUT_APX (input, 1): the adder result for the same operands.
REQ-010 The block SHALL have port out_valid (output, 1) and port out_ready (input, 1), the downstream handshake.
REQ-011 The block SHALL have ports SUM (output, SIZE) and COUT (output, 1): the registered adder result.
REQ-012 The block SHALL have ports ERR (output, 1) and ERR_DIST (output, SIZE+1): the mismatch flag and absolute error distance of the registered result.
REQ-013 The block SHALL have port MODE_EXACT (output, 1), driving the adder's carryoutselect; 1 selects the exact carry-out.
REQ-014 The block SHALL have ports WIN_DONE (output, 1), a one-cycle pulse, and WIN_ERRS (output, WIN_LOG2+1), the error count of the window just closed.

Function
REQ-015 The block SHALL drive in_ready = !out_valid || out_ready; a sample is accepted when in_valid && in_ready.
REQ-016 On acceptance, the block SHALL register SUM, COUT, ERR and ERR_DIST in the next cycle and set out_valid, giving 1-cycle latency.
REQ-017 The block SHALL compute the exact value as the (SIZE+1)-bit A+B+CIN and the approximate value as {COUT_APX,SUM_APX}.
REQ-018 ERR SHALL be 1 when exact and approximate differ; ERR_DIST SHALL be |exact-approx| in SIZE+1 bits.
REQ-019 out_valid SHALL clear after out_ready is sampled high with no new acceptance in the same cycle.
REQ-020 Registered outputs SHALL hold stable while out_valid && !out_ready.
REQ-021 Simultaneous drain and accept SHALL replace the output register with no bubble.
REQ-022 The sample counter SHALL increment per acceptance and wrap from 2^WIN_LOG2-1 to 0.
REQ-023 The error counter SHALL count accepted mismatches and saturate at 2^WIN_LOG2.
REQ-024 When the final sample of a window is accepted, the block SHALL set WIN_ERRS to the error counter including that sample.
REQ-025 On that same final-sample acceptance, the block SHALL pulse WIN_DONE in the following cycle.
REQ-026 On that same final-sample acceptance, the block SHALL reset the error counter to 0.
REQ-027 The FSM SHALL have states APPROX (MODE_EXACT=0) and EXACT (MODE_EXACT=1).
REQ-028 APPROX SHALL go to EXACT at window close when the window count exceeds ERR_TH.
REQ-029 On entry to EXACT, the hold counter SHALL load HOLD_WIN.
REQ-030 In EXACT, the hold counter SHALL decrement per closed window; when it reaches 0 the FSM SHALL return to APPROX at that window close.
REQ-031 MODE_EXACT SHALL change only in the cycle after a window close.
REQ-032 Counters SHALL advance only on acceptance; stalls SHALL not affect window contents.

Reset
REQ-033 Assertion of rst SHALL immediately clear all outputs, counters and hold counter, and set the FSM to APPROX, including mid-window and mid-stall.
REQ-034 After rst releases, in_ready SHALL be 1, out_valid 0 and WIN_ERRS 0.

Structure
REQ-035 The FSM state encoding and window/counter width constants SHALL be defined in shared package sara_pkg.
REQ-036 The error-distance computation SHALL be a combinational sub-module, sara_err_dist.

Verification
REQ-037 With SIZE=16, accept A=0x00FF, B=0x0001, CIN=0, SUM_APX=0x0100, COUT_APX=0 -> next cycle out_valid=1, SUM=0x0100, ERR=0, ERR_DIST=0.
REQ-038 Accept A=0x00FF, B=0x0001, SUM_APX=0x0000, COUT_APX=0 -> ERR=1, ERR_DIST=0x100.
REQ-039 Send 16 samples, 3 mismatching -> WIN_DONE pulse, WIN_ERRS=3, and MODE_EXACT=1 in the next cycle.
REQ-040 Remain in EXACT for 2 further windows -> MODE_EXACT returns to 0 after the second close.
REQ-041 With out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 and outputs stable; with out_ready=1 and in_valid=1 -> one transfer per cycle.
REQ-042 Assert rst after the 9th sample of a window -> all outputs 0 and MODE_EXACT=0; the next window closes 16 samples after release.
